// File: rtl/crc_frame_checker.sv
// rtl/crc_frame_checker.sv - receive-side CRC checker for sof/eof framed word streams
// Define CRC_CHK_STATS_EN to add saturating frame and error counters.
module crc_frame_checker #(
  parameter int unsigned           POLY_WIDTH = 8,
  parameter logic [POLY_WIDTH-1:0] POLY       = 8'hAF,
  parameter logic [POLY_WIDTH-1:0] INIT       = 8'h00,
  parameter bit                    REFLECT    = 1'b0,
  parameter logic [POLY_WIDTH-1:0] XOR_OUT    = 8'h00,
  parameter int unsigned           DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  sof_i,
  input  logic                  eof_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic                  crc_ok_o,
  output logic [POLY_WIDTH-1:0] crc_calc_o,
  output logic [POLY_WIDTH-1:0] crc_rx_o,
  output logic                  abort_o,
  output logic [15:0]           frame_cnt_o,
  output logic [15:0]           err_cnt_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_CHECK} state_t;

  function automatic logic [DATA_WIDTH-1:0] reflect_bytes(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if ((i / 8) * 8 + 7 < int'(DATA_WIDTH)) r[i] = d[(i / 8) * 8 + 7 - (i % 8)];
    end
    return r;
  endfunction

  function automatic logic [POLY_WIDTH-1:0] crc_fold(input logic [POLY_WIDTH-1:0] c,
                                                      input logic [DATA_WIDTH-1:0] d);
    logic [POLY_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] dd;
    logic                  fb;
    r  = c;
    dd = REFLECT ? reflect_bytes(d) : d;
    // MSB-first bit-serial LFSR, unrolled across the whole word
    for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
      fb = r[POLY_WIDTH-1] ^ dd[i];
      r  = (r << 1) ^ (POLY & {POLY_WIDTH{fb}});
    end
    return r;
  endfunction

  function automatic logic [POLY_WIDTH-1:0] crc_final(input logic [POLY_WIDTH-1:0] c);
    logic [POLY_WIDTH-1:0] r;
    r = c;
    if (REFLECT) begin
      for (int i = 0; i < int'(POLY_WIDTH); i++) r[i] = c[POLY_WIDTH-1-i];
    end
    return r ^ XOR_OUT;
  endfunction

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_int  = rst_sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic                  crc_ok_q, crc_ok_d;
  logic [POLY_WIDTH-1:0] crc_q, crc_d;
  logic [POLY_WIDTH-1:0] crc_calc_q, crc_calc_d;
  logic [POLY_WIDTH-1:0] crc_rx_q, crc_rx_d;
  logic [POLY_WIDTH-1:0] fin_src, fin_crc, base_crc;
  logic                  accept, finish;

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    crc_calc_d = crc_calc_q;
    crc_rx_d   = crc_rx_q;
    crc_ok_d   = crc_ok_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    finish     = 1'b0;
    fin_src    = INIT;
    fin_crc    = '0;
    accept     = valid_i & ready_q;
    // a sof word always (re)starts from INIT, even when it cuts a running frame
    base_crc   = sof_i ? INIT : crc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!sof_i) begin
            abort_d = 1'b1;
          end else if (eof_i) begin
            finish = 1'b1;
          end else begin
            crc_d   = crc_fold(INIT, data_i);
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          abort_d = sof_i;
          if (eof_i) begin
            finish  = 1'b1;
            fin_src = base_crc;
          end else begin
            crc_d = crc_fold(base_crc, data_i);
          end
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (finish) begin
      fin_crc    = crc_final(fin_src);
      crc_calc_d = fin_crc;
      crc_rx_d   = data_i[POLY_WIDTH-1:0];
      crc_ok_d   = (fin_crc == data_i[POLY_WIDTH-1:0]);
      done_d     = 1'b1;
      state_d    = ST_CHECK;
    end

    ready_d = (state_d != ST_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      crc_ok_q   <= 1'b0;
      crc_q      <= '0;
      crc_calc_q <= '0;
      crc_rx_q   <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      crc_ok_q   <= crc_ok_d;
      crc_q      <= crc_d;
      crc_calc_q <= crc_calc_d;
      crc_rx_q   <= crc_rx_d;
    end
  end

  assign ready_o    = ready_q;
  assign done_o     = done_q;
  assign abort_o    = abort_q;
  assign crc_ok_o   = crc_ok_q;
  assign crc_calc_o = crc_calc_q;
  assign crc_rx_o   = crc_rx_q;

`ifdef CRC_CHK_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // a failing zero-length frame that also aborts counts as a single error
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (done_d && (frame_cnt_q != 16'hFFFF)) frame_cnt_d = frame_cnt_q + 16'd1;
    if (((done_d && !crc_ok_d) || abort_d) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;
`else
  assign frame_cnt_o = '0;
  assign err_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_crc_frame_checker.sv
// tb/tb_crc_frame_checker.sv - directed self-checking bench for crc_frame_checker
module tb_crc_frame_checker;

`ifdef CRC_CHK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        sof_i = 1'b0;
  logic        eof_i = 1'b0;
  logic        ready_o, done_o, crc_ok_o, abort_o;
  logic [7:0]  crc_calc_o, crc_rx_o;
  logic [15:0] frame_cnt_o, err_cnt_o;

  int checks = 0;
  int failures = 0;

  crc_frame_checker dut (
    .clk(clk), .reset_n(reset_n), .data_i(data_i), .valid_i(valid_i),
    .sof_i(sof_i), .eof_i(eof_i), .ready_o(ready_o), .done_o(done_o),
    .crc_ok_o(crc_ok_o), .crc_calc_o(crc_calc_o), .crc_rx_o(crc_rx_o),
    .abort_o(abort_o), .frame_cnt_o(frame_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [15:0] d, input logic s, input logic e);
    @(negedge clk);
    data_i = d; sof_i = s; eof_i = e; valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
  endtask

  task automatic check_stats(input string tag, input int f, input int e);
    logic [15:0] ef, ee;
    ef = STATS ? 16'(f) : 16'd0;
    ee = STATS ? 16'(e) : 16'd0;
    checks++;
    if (frame_cnt_o !== ef) begin failures++; $display("FAIL %s_frame_cnt: got %0d want %0d", tag, frame_cnt_o, ef); end
    checks++;
    if (err_cnt_o !== ee) begin failures++; $display("FAIL %s_err_cnt: got %0d want %0d", tag, err_cnt_o, ee); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done_o); end
    checks++; if (abort_o !== 1'b0) begin failures++; $display("FAIL rst_abort: got %b want 0", abort_o); end
    checks++; if (crc_ok_o !== 1'b0) begin failures++; $display("FAIL rst_ok: got %b want 0", crc_ok_o); end
    checks++; if ({crc_calc_o, crc_rx_o} !== 16'h0000) begin failures++; $display("FAIL rst_crc: got %h/%h want 00/00", crc_calc_o, crc_rx_o); end
    check_stats("rst", 0, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_good_frame();
    drive(16'h0001, 1'b1, 1'b0);
    drive(16'h00AF, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL good_done: got %b want 1", done_o); end
    checks++; if (crc_calc_o !== 8'hAF) begin failures++; $display("FAIL good_calc: got %h want af", crc_calc_o); end
    checks++; if (crc_rx_o !== 8'hAF) begin failures++; $display("FAIL good_rx: got %h want af", crc_rx_o); end
    checks++; if (crc_ok_o !== 1'b1) begin failures++; $display("FAIL good_ok: got %b want 1", crc_ok_o); end
    check_stats("good", 1, 0);
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL good_done_pulse: got %b want 0", done_o); end
    checks++; if (crc_ok_o !== 1'b1) begin failures++; $display("FAIL good_ok_hold: got %b want 1", crc_ok_o); end
  endtask

  task automatic test_bad_frame();
    drive(16'h0001, 1'b1, 1'b0);
    drive(16'h00AE, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL bad_done: got %b want 1", done_o); end
    checks++; if (crc_ok_o !== 1'b0) begin failures++; $display("FAIL bad_ok: got %b want 0", crc_ok_o); end
    checks++; if (crc_calc_o !== 8'hAF) begin failures++; $display("FAIL bad_calc: got %h want af", crc_calc_o); end
    checks++; if (crc_rx_o !== 8'hAE) begin failures++; $display("FAIL bad_rx: got %h want ae", crc_rx_o); end
    check_stats("bad", 2, 1);
  endtask

  task automatic test_zero_length();
    drive(16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL zl_done: got %b want 1", done_o); end
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL zl_ready_check: got %b want 0", ready_o); end
    checks++; if (crc_calc_o !== 8'h00) begin failures++; $display("FAIL zl_calc: got %h want 00", crc_calc_o); end
    checks++; if (crc_ok_o !== 1'b1) begin failures++; $display("FAIL zl_ok: got %b want 1", crc_ok_o); end
    check_stats("zl", 3, 1);
    @(negedge clk);
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL zl_ready_after: got %b want 1", ready_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL zl_done_after: got %b want 0", done_o); end
  endtask

  task automatic test_restart();
    drive(16'h1234, 1'b1, 1'b0);
    drive(16'h0001, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (abort_o !== 1'b1) begin failures++; $display("FAIL rs_abort: got %b want 1", abort_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rs_done_early: got %b want 0", done_o); end
    @(negedge clk);
    checks++; if (abort_o !== 1'b0) begin failures++; $display("FAIL rs_abort_pulse: got %b want 0", abort_o); end
    drive(16'h00AF, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL rs_done: got %b want 1", done_o); end
    checks++; if (crc_ok_o !== 1'b1) begin failures++; $display("FAIL rs_ok: got %b want 1", crc_ok_o); end
    checks++; if (crc_calc_o !== 8'hAF) begin failures++; $display("FAIL rs_calc: got %h want af", crc_calc_o); end
    check_stats("rs", 4, 2);
  endtask

  task automatic test_sof_eof_in_run();
    drive(16'h1234, 1'b1, 1'b0);
    drive(16'h0055, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (abort_o !== 1'b1) begin failures++; $display("FAIL se_abort: got %b want 1", abort_o); end
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL se_done: got %b want 1", done_o); end
    checks++; if (crc_ok_o !== 1'b0) begin failures++; $display("FAIL se_ok: got %b want 0", crc_ok_o); end
    checks++; if (crc_calc_o !== 8'h00) begin failures++; $display("FAIL se_calc: got %h want 00", crc_calc_o); end
    checks++; if (crc_rx_o !== 8'h55) begin failures++; $display("FAIL se_rx: got %h want 55", crc_rx_o); end
    check_stats("se", 5, 3);
  endtask

  task automatic test_idle_abort_and_gaps();
    drive(16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (abort_o !== 1'b1) begin failures++; $display("FAIL ia_abort: got %b want 1", abort_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL ia_done: got %b want 0", done_o); end
    check_stats("ia", 5, 4);
    drive(16'h0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({done_o, abort_o, ready_o} !== 3'b001) begin failures++; $display("FAIL gap1_%0d: got %b want 001", i, {done_o, abort_o, ready_o}); end
    end
    drive(16'h0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    drive(16'h0077, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL gap_done: got %b want 1", done_o); end
    checks++; if (crc_calc_o !== 8'h77) begin failures++; $display("FAIL gap_calc: got %h want 77", crc_calc_o); end
    checks++; if (crc_ok_o !== 1'b1) begin failures++; $display("FAIL gap_ok: got %b want 1", crc_ok_o); end
    check_stats("gap", 6, 4);
  endtask

  task automatic test_reset_mid_frame();
    drive(16'h0100, 1'b1, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if ({done_o, abort_o, crc_ok_o, ready_o} !== 4'b0001) begin failures++; $display("FAIL mr_flags: got %b want 0001", {done_o, abort_o, crc_ok_o, ready_o}); end
    checks++; if ({crc_calc_o, crc_rx_o} !== 16'h0000) begin failures++; $display("FAIL mr_crc: got %h/%h want 00/00", crc_calc_o, crc_rx_o); end
    check_stats("mr", 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({done_o, abort_o} !== 2'b00) begin failures++; $display("FAIL mr_quiet_%0d: got %b want 00", i, {done_o, abort_o}); end
    end
    drive(16'h0100, 1'b1, 1'b0);
    drive(16'h0085, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL mr_done: got %b want 1", done_o); end
    checks++; if (crc_calc_o !== 8'h85) begin failures++; $display("FAIL mr_calc: got %h want 85", crc_calc_o); end
    checks++; if (crc_ok_o !== 1'b1) begin failures++; $display("FAIL mr_ok: got %b want 1", crc_ok_o); end
    check_stats("mr_after", 1, 0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_zero_length();
    test_restart();
    test_sof_eof_in_run();
    test_idle_abort_and_gaps();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
